// File: rtl/mat_mult_ctrl_pkg.sv
// Shared types and constants for the 6x6 multiplier host controller.
package mat_mult_ctrl_pkg;
   localparam int N_DIM  = 6;
   localparam int WORD_W = 27;
   localparam int IDX_W  = 3;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      RUN,
      CAPTURE,
      DONE
   } state_t;

   localparam logic MODE_PAR = 1'b0;
   localparam logic MODE_MAT = 1'b1;
endpackage

// File: rtl/mat_bank.sv
// N x N operand register file with one write port and the whole array on mat_o.
// Element (r,c) sits at word r*N+c of the flat output; out-of-range writes are dropped.
module mat_bank
   import mat_mult_ctrl_pkg::*;
#(
   parameter int N = N_DIM
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   wr_en_i,
   input  logic [IDX_W-1:0]       wr_row_i,
   input  logic [IDX_W-1:0]       wr_col_i,
   input  logic [WORD_W-1:0]      wr_data_i,
   output logic [N*N*WORD_W-1:0]  mat_o
);

   word_t mem_q [N][N];
   logic  in_range;

   assign in_range = (int'(wr_row_i) < N) && (int'(wr_col_i) < N);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               mem_q[r][c] <= '0;
            end
         end
      end else if (wr_en_i && in_range) begin
         mem_q[wr_row_i][wr_col_i] <= wr_data_i;
      end
   end

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         assign mat_o[(r*N+c)*WORD_W +: WORD_W] = mem_q[r][c];
      end
   end

endmodule

// File: rtl/mat_mult_ctrl.sv
// Host-side initiator for the 6x6 multiplier: holds A/B operands, sequences en/mat_mode, captures result.
// Optional sticky protocol error flag is built only when MAT_MULT_CTRL_ERR_EN is defined.
module mat_mult_ctrl
   import mat_mult_ctrl_pkg::*;
#(
   parameter int N          = N_DIM,
   parameter int MAT_CYCLES = 12,
   parameter int PAR_CYCLES = 6
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   wr_en_i,
   input  logic                   wr_sel_i,
   input  logic [IDX_W-1:0]       wr_row_i,
   input  logic [IDX_W-1:0]       wr_col_i,
   input  logic [WORD_W-1:0]      wr_data_i,
   input  logic                   start_i,
   input  logic                   mode_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   input  logic [IDX_W-1:0]       rd_row_i,
   input  logic [IDX_W-1:0]       rd_col_i,
   output logic [WORD_W-1:0]      rd_data_o,
   output logic                   mm_clk_o,
   output logic                   mm_rst_o,
   output logic                   mm_en_o,
   output logic                   mm_mat_mode_o,
   output logic [N*N*WORD_W-1:0]  mm_dataa_o,
   output logic [N*N*WORD_W-1:0]  mm_datab_o,
   input  logic [N*N*WORD_W-1:0]  mm_result_i
);

   localparam int CNT_MAX = (MAT_CYCLES > PAR_CYCLES) ? MAT_CYCLES : PAR_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   state_t             state_q, state_d;
   logic               mode_q, mode_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   run_last;
   logic               capture;
   logic               wr_a, wr_b;
   word_t              res_q [N][N];

   assign mm_clk_o = clk_i;
   assign mm_rst_o = ~rst_n_i;
   assign run_last = (mode_q == MODE_MAT) ? CNT_W'(MAT_CYCLES - 1) : CNT_W'(PAR_CYCLES - 1);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         mode_q  <= MODE_PAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      cnt_d         = cnt_q;
      busy_o        = 1'b0;
      done_o        = 1'b0;
      mm_en_o       = 1'b0;
      mm_mat_mode_o = MODE_PAR;
      capture       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               mode_d  = mode_i;
               state_d = SETUP;
            end
         end
         // en=0 with mat_mode=0 clears the multiplier's internal phase counter
         SETUP: begin
            busy_o  = 1'b1;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            busy_o        = 1'b1;
            mm_en_o       = 1'b1;
            mm_mat_mode_o = mode_q;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == run_last) begin
               cnt_d   = '0;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            busy_o  = 1'b1;
            capture = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands must stay frozen while the multiplier is consuming them.
   assign wr_a = wr_en_i && !busy_o && !wr_sel_i;
   assign wr_b = wr_en_i && !busy_o &&  wr_sel_i;

   mat_bank #(.N(N)) u_bank_a (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .wr_en_i   (wr_a),
      .wr_row_i  (wr_row_i),
      .wr_col_i  (wr_col_i),
      .wr_data_i (wr_data_i),
      .mat_o     (mm_dataa_o)
   );

   mat_bank #(.N(N)) u_bank_b (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .wr_en_i   (wr_b),
      .wr_row_i  (wr_row_i),
      .wr_col_i  (wr_col_i),
      .wr_data_i (wr_data_i),
      .mat_o     (mm_datab_o)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               res_q[r][c] <= '0;
            end
         end
      end else if (capture) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               res_q[r][c] <= mm_result_i[(r*N+c)*WORD_W +: WORD_W];
            end
         end
      end
   end

   always_comb begin
      rd_data_o = '0;
      if ((int'(rd_row_i) < N) && (int'(rd_col_i) < N)) begin
         rd_data_o = res_q[rd_row_i][rd_col_i];
      end
   end

`ifdef MAT_MULT_CTRL_ERR_EN
   logic err_q, err_d;
   logic wr_idx_bad;

   assign wr_idx_bad = (int'(wr_row_i) >= N) || (int'(wr_col_i) >= N);

   always_comb begin
      err_d = err_q;
      if ((busy_o && (wr_en_i || start_i)) || (wr_en_i && wr_idx_bad)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mat_mult_ctrl.sv
// Bench for mat_mult_ctrl: a behavioural multiplier stand-in plus shadow operand/result arrays.
module tb_mat_mult_ctrl;
   import mat_mult_ctrl_pkg::*;

   localparam int NN    = N_DIM * N_DIM;
   localparam int FW    = NN * WORD_W;
   localparam int MAT_C = 12;
   localparam int PAR_C = 6;
   localparam logic [26:0] ONE_Q = 27'h2000000;
   localparam logic [26:0] JUNK  = 27'h5A5A5A5;

   typedef logic [FW-1:0] flat_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, mode = 1'b0;
   logic [2:0]  wr_row = '0, wr_col = '0, rd_row = '0, rd_col = '0;
   logic [26:0] wr_data = '0;
   logic [26:0] rd_data;
   logic        busy, done, err;
   logic        mm_clk, mm_rst, mm_en, mm_mat_mode;
   flat_t       mm_dataa, mm_datab;
   flat_t       mm_result;

   int passed = 0;
   int total  = 0;

   word_t sa   [N_DIM][N_DIM];
   word_t sb   [N_DIM][N_DIM];
   word_t sres [N_DIM][N_DIM];
   bit    err_exp;

   always #5 clk = ~clk;

   mat_mult_ctrl dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_row_i(wr_row), .wr_col_i(wr_col), .wr_data_i(wr_data),
      .start_i(start), .mode_i(mode),
      .busy_o(busy), .done_o(done), .err_o(err),
      .rd_row_i(rd_row), .rd_col_i(rd_col), .rd_data_o(rd_data),
      .mm_clk_o(mm_clk), .mm_rst_o(mm_rst), .mm_en_o(mm_en), .mm_mat_mode_o(mm_mat_mode),
      .mm_dataa_o(mm_dataa), .mm_datab_o(mm_datab), .mm_result_i(mm_result)
   );

   function automatic word_t el(flat_t f, int r, int c);
      return f[(r*N_DIM+c)*WORD_W +: WORD_W];
   endfunction

   // Q2.25 arithmetic: 27'h2000000 is 1.0
   function automatic flat_t mult(flat_t a, flat_t b, bit m);
      flat_t o = '0;
      for (int r = 0; r < N_DIM; r++) begin
         for (int c = 0; c < N_DIM; c++) begin
            longint unsigned acc = 0;
            longint unsigned x, y;
            if (m) begin
               for (int k = 0; k < N_DIM; k++) begin
                  x = el(a, r, k);
                  y = el(b, k, c);
                  acc += x * y;
               end
            end else begin
               x = el(a, r, c);
               y = el(b, r, c);
               acc = x * y;
            end
            o[(r*N_DIM+c)*WORD_W +: WORD_W] = 27'(acc >> 25);
         end
      end
      return o;
   endfunction

   // Multiplier stand-in: result is only valid after exactly C en cycles, junk otherwise.
   int mock_cnt;
   always @(posedge mm_clk) begin
      if (mm_rst) begin
         mock_cnt  <= 0;
         mm_result <= '0;
      end else if (!mm_en && !mm_mat_mode) begin
         mock_cnt <= 0;
      end else if (mm_en) begin
         if (mock_cnt + 1 == (mm_mat_mode ? MAT_C : PAR_C))
            mm_result <= mult(mm_dataa, mm_datab, mm_mat_mode);
         else
            mm_result <= {NN{JUNK}};
         mock_cnt <= mock_cnt + 1;
      end
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_result(bit m);
      for (int r = 0; r < N_DIM; r++) begin
         for (int c = 0; c < N_DIM; c++) begin
            longint unsigned acc = 0;
            if (m) begin
               for (int k = 0; k < N_DIM; k++) acc += longint'(sa[r][k]) * longint'(sb[k][c]);
            end else begin
               acc = longint'(sa[r][c]) * longint'(sb[r][c]);
            end
            sres[r][c] = 27'(acc >> 25);
         end
      end
   endtask

   task automatic clear_model();
      for (int r = 0; r < N_DIM; r++) begin
         for (int c = 0; c < N_DIM; c++) begin
            sa[r][c] = '0; sb[r][c] = '0; sres[r][c] = '0;
         end
      end
      err_exp = 1'b0;
   endtask

   task automatic do_write(bit sel, int r, int c, logic [26:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = sel; wr_row = 3'(r); wr_col = 3'(c); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      if (r < N_DIM && c < N_DIM) begin
         if (sel) sb[r][c] = d;
         else     sa[r][c] = d;
      end else begin
`ifdef MAT_MULT_CTRL_ERR_EN
         err_exp = 1'b1;
`endif
      end
   endtask

   task automatic check_banks(string tag);
      int  fr = 0, fc = 0;
      bit  found = 0;
      for (int r = 0; r < N_DIM; r++)
         for (int c = 0; c < N_DIM; c++)
            if (!found && el(mm_dataa, r, c) !== sa[r][c]) begin found = 1; fr = r; fc = c; end
      check({tag, "_bankA"}, el(mm_dataa, fr, fc), sa[fr][fc]);
      found = 0; fr = 0; fc = 0;
      for (int r = 0; r < N_DIM; r++)
         for (int c = 0; c < N_DIM; c++)
            if (!found && el(mm_datab, r, c) !== sb[r][c]) begin found = 1; fr = r; fc = c; end
      check({tag, "_bankB"}, el(mm_datab, fr, fc), sb[fr][fc]);
   endtask

   task automatic check_results(string tag);
      @(negedge clk);
      for (int r = 0; r < N_DIM; r++) begin
         for (int c = 0; c < N_DIM; c++) begin
            rd_row = 3'(r); rd_col = 3'(c);
            #1;
            check($sformatf("%s_rd_%0d_%0d", tag, r, c), rd_data, sres[r][c]);
         end
      end
      rd_row = 3'd6; rd_col = 3'd0; #1;
      check({tag, "_rd_row6"}, rd_data, 27'd0);
      rd_row = 3'd2; rd_col = 3'd7; #1;
      check({tag, "_rd_col7"}, rd_data, 27'd0);
   endtask

   // Launch one run and watch every cycle until well past the expected done.
   task automatic do_run(string tag, bit m, bit inject);
      int C = m ? MAT_C : PAR_C;
      int en_cnt = 0, done_at = -1, done_cnt = 0, mode_bad = 0, busy_bad = 0;
      int pr, pc;
      pr = $urandom_range(0, N_DIM-1);
      pc = $urandom_range(0, N_DIM-1);
      model_result(m);
      @(negedge clk);
      start = 1'b1; mode = m; rd_row = 3'(pr); rd_col = 3'(pc);
      for (int n = 1; n <= C + 6; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            start = 1'b0;
            mode  = ~m;
            check({tag, "_setup"}, {mm_en, mm_mat_mode, busy}, 3'b001);
         end
         if (inject && n == 4) begin
            start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd0; wr_col = 3'd0;
            wr_data = 27'h1234567;
`ifdef MAT_MULT_CTRL_ERR_EN
            err_exp = 1'b1;
`endif
         end
         if (inject && n == 5) begin
            start = 1'b0; wr_en = 1'b0;
         end
         if (mm_en === 1'b1) begin
            en_cnt++;
            if (mm_mat_mode !== m) mode_bad++;
         end
         if (n <= C + 2 && busy !== 1'b1) busy_bad++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = n;
               check({tag, "_rd_at_done"}, rd_data, sres[pr][pc]);
               check({tag, "_busy_at_done"}, busy, 1'b0);
            end
         end
      end
      check({tag, "_en_cycles"}, en_cnt, C);
      check({tag, "_mode_during_en"}, mode_bad, 0);
      check({tag, "_busy_span"}, busy_bad, 0);
      check({tag, "_done_latency"}, done_at, C + 3);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_err"}, err, err_exp);
      check_banks(tag);
   endtask

   typedef struct {
      bit          sel;
      int          row;
      int          col;
      logic [26:0] data;
      bit          accept;
   } wvec_t;

   initial begin
      wvec_t tbl[8];
      tbl[0] = '{1'b0, 0, 0, 27'h0000001, 1'b1};
      tbl[1] = '{1'b1, 5, 5, 27'h7FFFFFF, 1'b1};
      tbl[2] = '{1'b0, 6, 0, 27'h1111111, 1'b0};
      tbl[3] = '{1'b1, 0, 7, 27'h2222222, 1'b0};
      tbl[4] = '{1'b0, 5, 0, 27'h3333333, 1'b1};
      tbl[5] = '{1'b1, 7, 7, 27'h4444444, 1'b0};
      tbl[6] = '{1'b0, 2, 3, 27'h5555555, 1'b1};
      tbl[7] = '{1'b0, 2, 3, 27'h6666666, 1'b1};

      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check("rst_mm_rst", mm_rst, 1'b1);
      check("rst_outputs", {busy, done, err, mm_en, mm_mat_mode}, 5'b0);
      @(negedge clk); rst_n = 1'b1;
      #1;
      check("rel_mm_rst", mm_rst, 1'b0);
      check_banks("reset");
      check_results("reset");

      // Table-driven operand writes, including out-of-range indices.
      for (int i = 0; i < 8; i++) begin
         do_write(tbl[i].sel, tbl[i].row, tbl[i].col, tbl[i].data);
         if (tbl[i].accept)
            check($sformatf("tbl%0d_elem", i),
                  tbl[i].sel ? el(mm_datab, tbl[i].row, tbl[i].col) : el(mm_dataa, tbl[i].row, tbl[i].col),
                  tbl[i].data);
         check_banks($sformatf("tbl%0d", i));
         check($sformatf("tbl%0d_err", i), err, err_exp);
      end

      // Identity x B in matrix mode -> result equals B.
      @(negedge clk); rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      clear_model();
      for (int r = 0; r < N_DIM; r++)
         for (int c = 0; c < N_DIM; c++) begin
            do_write(1'b0, r, c, (r == c) ? ONE_Q : 27'd0);
            do_write(1'b1, r, c, 27'({r[2:0], c[2:0]}));
         end
      do_run("ident", MODE_MAT, 1'b0);
      check_results("ident");
      check("ident_eq_B_5_4", sres[5][4], 27'h2C);

      // Element-wise, all operands 1.0.
      for (int r = 0; r < N_DIM; r++)
         for (int c = 0; c < N_DIM; c++) begin
            do_write(1'b0, r, c, ONE_Q);
            do_write(1'b1, r, c, ONE_Q);
         end
      do_run("par", MODE_PAR, 1'b0);
      check_results("par");

      // Start and A write during RUN must be ignored.
      do_run("inject", MODE_MAT, 1'b1);
      check_results("inject");

      // Randomised writes and runs.
      for (int it = 0; it < 6; it++) begin
         for (int w = 0; w < 10; w++)
            do_write(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), 27'($urandom));
         do_run($sformatf("rnd%0d", it), 1'($urandom), 1'b0);
         check_results($sformatf("rnd%0d", it));
      end

      // Reset asserted in the 5th RUN cycle.
      begin
         int late_done = 0;
         @(negedge clk); start = 1'b1; mode = MODE_MAT;
         @(posedge clk); #1; start = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         check("abort_pre_en", mm_en, 1'b1);
         @(negedge clk); rst_n = 1'b0;
         #1;
         check("abort_mm_rst", mm_rst, 1'b1);
         @(posedge clk); #1;
         check("abort_outputs", {busy, done, err, mm_en, mm_mat_mode}, 5'b0);
         clear_model();
         @(negedge clk); rst_n = 1'b1;
         for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) late_done++;
         end
         check("abort_no_done", late_done, 0);
         check_banks("abort");
         check_results("abort");
      end

      // Fresh run after abort.
      for (int i = 0; i < 8; i++)
         do_write(1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5), 27'($urandom));
      do_run("fresh", MODE_PAR, 1'b0);
      check_results("fresh");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passed, total);
      $fatal(1, "watchdog");
   end

endmodule
